enhanced_datapath: RTL
======================

Name: enhanced_datapath

Overview:
- Datapath companion to the `enhanced` control-unit FSM. It consumes the FSM's control word and returns the status and opcode the FSM branches on: `ir[2:0]`, `Aeq0`, `Apos`.
- Contains:
  - PC register
  - IR register
  - accumulator A
  - single-port program/data RAM
  - add/sub unit
  - A-input mux
  - a program-load port used by benches and boot logic
- Instruction format: `ir[7:5]` = opcode, `ir[4:0]` = memory address.

Parameters:
- DATA_W, 8, width of A, IR and memory words; opcode is always the top 3 bits.
- ADDR_W, 5, width of PC and memory address; memory depth 2^ADDR_W.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- IRload  in  1  load IR from memory read data
- JMPmux  in  1  PC next-value select: 0 = PC+1, 1 = IR address field
- PCload  in  1  load PC with the JMPmux-selected value
- Meminst  in  1  memory address select: 0 = PC, 1 = IR address field
- MemWr  in  1  write A into memory at the selected address
- Asel  in  2  A input select: 00 = add/sub result, 01 = `in_data`, 10 = memory read data, 11 = zero
- Aload  in  1  load A from the Asel mux
- Sub  in  1  add/sub unit: 0 = A+M, 1 = A−M
- Halt  in  1  stop request from the control unit
- in_data  in  DATA_W  external input port (IN instruction)
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data
- ir  out  3  opcode, `IR[DATA_W-1:DATA_W-3]`
- Aeq0  out  1  A == 0
- Apos  out  1  A > 0 as signed (`A[DATA_W-1]`==0 and A != 0)
- out_data  out  DATA_W  current A (output port)
- halted  out  1  sticky halt flag

Behaviour:
- Reset, asynchronous while reset==0:
  - PC=0, IR=0, A=0, halted=0.
  - Consequently `ir`=000, `Aeq0`=1, `Apos`=0, `out_data`=0.
  - Memory contents are not reset.
  - Reset asserted mid-instruction aborts any pending register or memory update in that cycle.
- Memory:
  - Asynchronous read: M = mem[addr], where addr = Meminst ? IR[ADDR_W-1:0] : PC.
  - Synchronous write on the rising edge.
  - Write source priority: if prog_we=1, then mem[prog_addr] <= prog_data and MemWr is ignored that cycle. Otherwise, if MemWr=1 and halted=0, then mem[addr] <= A.
  - A read of the address being written returns the old data until the edge.
- IR: if IRload=1 and halted=0, then IR <= M.
- PC:
  - if PCload=1 and halted=0, then PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1.
  - PC+1 wraps modulo 2^ADDR_W (31 -> 0).
- A:
  - if Aload=1 and halted=0, then A <= mux(Asel).
  - The add/sub result is (A + M) or (A − M) modulo 2^DATA_W; no carry or overflow flag.
- Status outputs `Aeq0`, `Apos`, `ir`, `out_data` are combinational from the registers, so they are valid in the cycle after the load. The FSM's JZ/JPOS decisions therefore see A as of the previous instruction.
- Halt:
  - Halt=1 at a rising edge sets halted=1; it stays set until reset.
  - While halted=1, IRload, PCload, Aload and MemWr have no effect.
  - prog_we still writes, so a new program can be loaded before reset is released again.
- Simultaneous events:
  - Halt together with a load in the same cycle: the load takes effect and halted sets; later loads are blocked.
  - IRload and PCload in the same cycle (fetch): IR captures M addressed by the old PC, and PC increments.
- Latency: one clock per control word; there is no internal FSM.

Test Plan:
- Reset and status:
  - Pulse reset=0 mid-cycle -> PC=0, IR=0, A=0 immediately (async); Aeq0=1, Apos=0, halted=0.
- Fetch:
  - prog-load mem[0]=8'h07, mem[7]=8'h05.
  - Apply IRload=1, PCload=1, JMPmux=0 for one edge -> IR=8'h07, ir=000, PC=1.
  - Then Meminst=1, Asel=10, Aload=1 -> A=8'h05, Apos=1, Aeq0=0.
- Add/sub wrap:
  - With A=8'h05 and mem[7]=8'h05:
    - Sub=1, Asel=00, Aload=1 -> A=0, Aeq0=1.
    - Repeat Sub=1 -> A=8'hFB, Apos=0, Aeq0=0.
    - Sub=0 twice -> A=8'h00 then 8'h05.
- Store:
  - Set A=8'h3C via Asel=01, in_data=8'h3C.
  - IR address 5'h1F with Meminst=1, MemWr=1 -> mem[31]=8'h3C.
  - Readback: Meminst=1, Asel=10, Aload=1 returns 8'h3C.
- Jump and wrap:
  - IR=8'hA9, PCload=1, JMPmux=1 -> PC=9.
  - Load PC to 31, then PCload=1, JMPmux=0 -> PC=0.
- Halt and priority:
  - Halt=1 for one edge -> halted=1.
  - Subsequent Aload/PCload/IRload/MemWr -> no change.
  - prog_we with MemWr in the same cycle -> only the prog_data write lands.
  - reset=0 -> halted=0.

Source files
------------

// File: rtl/enhanced_datapath_if.sv
// rtl/enhanced_datapath_if.sv - control word, status and program-load bundle for enhanced_datapath
interface enhanced_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    // control word from the control unit
    logic              IRload;
    logic              JMPmux;
    logic              PCload;
    logic              Meminst;
    logic              MemWr;
    logic [1:0]        Asel;
    logic              Aload;
    logic              Sub;
    logic              Halt;
    logic [DATA_W-1:0] in_data;

    // program-load port
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    // status back to the control unit
    logic [2:0]        ir;
    logic              Aeq0;
    logic              Apos;
    logic [DATA_W-1:0] out_data;
    logic              halted;

    modport master (
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, in_data,
        output prog_we, prog_addr, prog_data,
        input  ir, Aeq0, Apos, out_data, halted
    );

    modport slave (
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, in_data,
        input  prog_we, prog_addr, prog_data,
        output ir, Aeq0, Apos, out_data, halted
    );
endinterface

// File: rtl/enhanced_datapath.sv
// rtl/enhanced_datapath.sv - PC/IR/accumulator datapath with RAM and add/sub for the enhanced control unit
module enhanced_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input logic               clock,
    input logic               reset,
    enhanced_datapath_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic              r_halted;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_ir_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_a_next;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_ir_addr = r_ir[ADDR_W-1:0];

    // Address select, asynchronous RAM read, add/sub unit and A-input / PC-next muxes
    always_comb begin
        w_addr    = bus.Meminst ? w_ir_addr : r_pc;
        w_m       = r_mem[w_addr];
        w_alu     = bus.Sub ? (r_a - w_m) : (r_a + w_m);
        w_pc_next = bus.JMPmux ? w_ir_addr : (r_pc + ADDR_W'(1));
        w_a_next  = '0;
        case (bus.Asel)
            2'b00:   w_a_next = w_alu;
            2'b01:   w_a_next = bus.in_data;
            2'b10:   w_a_next = w_m;
            default: w_a_next = '0;
        endcase
    end

    // Architectural registers; once halted only reset brings the datapath back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_halted <= 1'b0;
        end else begin
            if (bus.Halt) begin
                r_halted <= 1'b1;
            end
            if (!r_halted) begin
                if (bus.IRload) begin
                    r_ir <= w_m;
                end
                if (bus.PCload) begin
                    r_pc <= w_pc_next;
                end
                if (bus.Aload) begin
                    r_a <= w_a_next;
                end
            end
        end
    end

    // RAM write: program-load port wins over MemWr; an edge seen under reset writes nothing
    always_ff @(posedge clock) begin
        if (reset) begin
            if (bus.prog_we) begin
                r_mem[bus.prog_addr] <= bus.prog_data;
            end else if (bus.MemWr && !r_halted) begin
                r_mem[w_addr] <= r_a;
            end
        end
    end

    assign bus.ir       = r_ir[DATA_W-1 -: 3];
    assign bus.Aeq0     = (r_a == '0);
    assign bus.Apos     = !r_a[DATA_W-1] && (r_a != '0);
    assign bus.out_data = r_a;
    assign bus.halted   = r_halted;
endmodule
